// File: rtl/spi_cmd_regfile_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_regfile_if
// Byte-level link between spi_slave and spi_cmd_regfile.
//   ss       : slave select, active-low, synchronous to clk (high = idle)
//   rx_data  : received byte (spi_slave data_out)
//   rx_rdy   : received-byte-valid level (spi_slave data_rdy)
//   tx_data  : next byte to shift out (spi_slave data_in)
//   tx_latch : one-cycle load strobe for tx_data (spi_slave data_latch)
// Modports: master = spi_slave side, slave = register file side.
// -----------------------------------------------------------------------------
interface spi_cmd_regfile_if;
  logic       ss;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [7:0] tx_data;
  logic       tx_latch;

  modport master (
    output ss,
    output rx_data,
    output rx_rdy,
    input  tx_data,
    input  tx_latch
  );

  modport slave (
    input  ss,
    input  rx_data,
    input  rx_rdy,
    output tx_data,
    output tx_latch
  );
endinterface

// File: rtl/spi_cmd_regfile.sv
// -----------------------------------------------------------------------------
// spi_cmd_regfile
// Command decoder and register file behind spi_slave. Each ss-low frame is one
// transaction: a command byte (bit7 = write, bits[6:0] = start address), then
// burst data bytes with address auto-increment (modulo NUM_REGS). Reads return
// reg[addr] through tx_data/tx_latch one clock after the triggering byte.
//
// Ports:
//   clk      : system clock (shared with spi_slave)
//   rst      : asynchronous active-low reset
//   bus      : spi_cmd_regfile_if.slave (ss, rx_data, rx_rdy, tx_data, tx_latch)
//   reg_out  : flat register contents, reg n = reg_out[8n+7:8n]
//   wr_stb   : (SPI_CMD_REGFILE_WSTB_EN only) one-cycle pulse after each write
//   wr_addr  : (SPI_CMD_REGFILE_WSTB_EN only) address of that write
//
// Build option: define SPI_CMD_REGFILE_WSTB_EN to add the wr_stb/wr_addr ports.
// -----------------------------------------------------------------------------
module spi_cmd_regfile #(
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00,
  localparam int         NUM_REGS  = 32'sd1 <<< ADDR_W,
  localparam int         OUT_W     = NUM_REGS * 32'sd8
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_cmd_regfile_if.slave     bus,
  output logic [OUT_W-32'sd1:0] reg_out
`ifdef SPI_CMD_REGFILE_WSTB_EN
  ,
  output logic                 wr_stb,
  output logic [ADDR_W-32'sd1:0] wr_addr
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(1'b0);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [ADDR_W-1:0] addr_inc_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic              rx_rdy_q_r;
  logic              byte_evt_s;
  logic              cmd_bad_s;
  logic              wr_en_s;
  logic              tx_load_s;
  logic [7:0]        tx_data_nxt_s;
  logic [7:0]        tx_data_r;
  logic              tx_latch_r;
  logic [7:0]        regs_r [NUM_REGS];

  // A level held high on rx_rdy yields a single byte event on its rising edge.
  assign byte_evt_s = bus.rx_rdy & ~rx_rdy_q_r;
  assign cmd_addr_s = bus.rx_data[ADDR_W-1:0];
  // Any address bit above the implemented range makes the whole frame invalid.
  assign cmd_bad_s  = ((bus.rx_data[6:0] >> ADDR_W) != 7'h00);
  assign addr_inc_s = addr_r + ADDR_ONE;

  // rx_rdy delay register for the byte-event edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_rdy_q_r <= 1'b0;
    end else begin
      rx_rdy_q_r <= bus.rx_rdy;
    end
  end

  // FSM state and burst address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      addr_r  <= ADDR_ZERO;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  // Next-state, address, write-enable and tx load decode.
  // A load computed here lands in tx_data_r/tx_latch_r on the event edge, so
  // the strobe appears exactly one clock after the byte event.
  always_comb begin
    state_nxt_s   = state_r;
    addr_nxt_s    = addr_r;
    wr_en_s       = 1'b0;
    tx_load_s     = 1'b0;
    tx_data_nxt_s = tx_data_r;
    if (bus.ss) begin
      // Deselect wins over any coincident byte event.
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_CMD;
          addr_nxt_s  = ADDR_ZERO;
        end
        ST_CMD: begin
          if (byte_evt_s) begin
            addr_nxt_s = cmd_addr_s;
            if (cmd_bad_s) begin
              state_nxt_s   = ST_DISCARD;
              tx_load_s     = 1'b1;
              tx_data_nxt_s = 8'h00;
            end else if (bus.rx_data[7]) begin
              state_nxt_s = ST_WRITE;
            end else begin
              state_nxt_s   = ST_READ;
              tx_load_s     = 1'b1;
              tx_data_nxt_s = regs_r[cmd_addr_s];
            end
          end else begin
            state_nxt_s = ST_CMD;
          end
        end
        ST_WRITE: begin
          if (byte_evt_s) begin
            wr_en_s    = 1'b1;
            addr_nxt_s = addr_inc_s;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        ST_READ: begin
          if (byte_evt_s) begin
            addr_nxt_s    = addr_inc_s;
            tx_load_s     = 1'b1;
            tx_data_nxt_s = regs_r[addr_inc_s];
          end else begin
            tx_load_s = 1'b0;
          end
        end
        ST_DISCARD: begin
          state_nxt_s = ST_DISCARD;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Register file storage; each accepted write byte lands whole in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else if (wr_en_s) begin
      regs_r[addr_r] <= bus.rx_data;
    end
  end

  // Registered tx path: tx_data holds its last value between loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_r  <= 8'h00;
      tx_latch_r <= 1'b0;
    end else begin
      tx_latch_r <= tx_load_s;
      if (tx_load_s) begin
        tx_data_r <= tx_data_nxt_s;
      end
    end
  end

  assign bus.tx_data  = tx_data_r;
  assign bus.tx_latch = tx_latch_r;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
    assign reg_out[gi*8 +: 8] = regs_r[gi];
  end

`ifdef SPI_CMD_REGFILE_WSTB_EN
  logic              wr_stb_r;
  logic [ADDR_W-1:0] wr_addr_r;

  // Write notification: pulse in the cycle after each register write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_stb_r  <= 1'b0;
      wr_addr_r <= ADDR_ZERO;
    end else begin
      wr_stb_r <= wr_en_s;
      if (wr_en_s) begin
        wr_addr_r <= addr_r;
      end
    end
  end

  assign wr_stb  = wr_stb_r;
  assign wr_addr = wr_addr_r;
`endif

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_regfile
// Table of frames applied in a loop; read data and write strobes are predicted
// by a frame-level model, queued when bytes are driven, and compared when the
// DUT strobes. Hand-written sequences cover ss/byte collisions and async reset.
// -----------------------------------------------------------------------------
module tb_spi_cmd_regfile;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] reg_out;
`ifdef SPI_CMD_REGFILE_WSTB_EN
  logic         wr_stb;
  logic [3:0]   wr_addr;
`endif

  spi_cmd_regfile_if bus();

  spi_cmd_regfile #(.ADDR_W(4), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .reg_out (reg_out)
`ifdef SPI_CMD_REGFILE_WSTB_EN
    ,
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] model [16];

  typedef struct { logic [7:0] data; int cyc; } tx_exp_t;
  typedef struct { logic [3:0] addr; int cyc; } wr_exp_t;
  tx_exp_t tx_q [$];
  wr_exp_t wr_q [$];

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    int         hold;
    logic [3:0] idx;
    logic [7:0] val;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  // Scoreboard for tx strobes: data and the exact cycle it must appear.
  always @(negedge clk) begin
    tx_exp_t e;
    if (rst === 1'b1 && bus.tx_latch === 1'b1) begin
      if (tx_q.size() == 0) begin
        chk("tx_latch_unexpected", 128'(1), 128'(0));
      end else begin
        e = tx_q.pop_front();
        chk("tx_data", 128'(bus.tx_data), 128'(e.data));
        chk("tx_latch_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

`ifdef SPI_CMD_REGFILE_WSTB_EN
  // Scoreboard for write strobes.
  always @(negedge clk) begin
    wr_exp_t w;
    if (rst === 1'b1 && wr_stb === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("wr_stb_unexpected", 128'(1), 128'(0));
      end else begin
        w = wr_q.pop_front();
        chk("wr_addr", 128'(wr_addr), 128'(w.addr));
        chk("wr_stb_cycle", 128'(cyc), 128'(w.cyc));
      end
    end
  end
`endif

  // One received byte: rx_rdy high for 'hold' edges, then low for one edge.
  task automatic send_byte(input logic [7:0] b, input int hold,
                           input logic exp_tx, input logic [7:0] tx_val,
                           input logic exp_wr, input logic [3:0] wr_a);
    tx_exp_t te;
    wr_exp_t we;
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    if (exp_tx) begin
      te.data = tx_val; te.cyc = cyc + 1; tx_q.push_back(te);
    end
    if (exp_wr) begin
      we.addr = wr_a; we.cyc = cyc + 1; wr_q.push_back(we);
    end
    repeat (hold) @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int n, input int hold);
    logic [7:0] bs [3];
    logic [3:0] a;
    logic       bad;
    logic       wr;
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    @(posedge clk); #1 bus.ss = 1'b0;
    repeat (2) @(posedge clk);
    bad = (b0[6:4] != 3'b000);
    wr  = b0[7];
    a   = b0[3:0];
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        if (bad)     send_byte(bs[0], hold, 1'b1, 8'h00, 1'b0, 4'h0);
        else if (wr) send_byte(bs[0], hold, 1'b0, 8'h00, 1'b0, 4'h0);
        else         send_byte(bs[0], hold, 1'b1, model[a], 1'b0, 4'h0);
      end else if (bad) begin
        send_byte(bs[i], hold, 1'b0, 8'h00, 1'b0, 4'h0);
      end else if (wr) begin
        send_byte(bs[i], hold, 1'b0, 8'h00, 1'b1, a);
        model[a] = bs[i];
        a = a + 4'h1;
      end else begin
        a = a + 4'h1;
        send_byte(bs[i], hold, 1'b1, model[a], 1'b0, 4'h0);
      end
    end
    repeat (3) @(posedge clk);
    #1 bus.ss = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("tx_q_drained", 128'(tx_q.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h83, 8'hA5, 8'h5A, 3, 1, 4'd3,  8'hA5};
    vecs[1]  = '{8'h03, 8'h00, 8'h00, 3, 1, 4'd4,  8'h5A};
    vecs[2]  = '{8'h8F, 8'h11, 8'h22, 3, 1, 4'd15, 8'h11};
    vecs[3]  = '{8'h0F, 8'h00, 8'h00, 2, 1, 4'd0,  8'h22};
    vecs[4]  = '{8'hC0, 8'hFF, 8'h00, 2, 1, 4'd0,  8'h22};
    vecs[5]  = '{8'h82, 8'h3C, 8'h00, 2, 1, 4'd2,  8'h3C};
    vecs[6]  = '{8'hFF, 8'h77, 8'h00, 2, 1, 4'd7,  8'h00};
    vecs[7]  = '{8'h87, 8'h01, 8'h02, 3, 1, 4'd8,  8'h02};
    vecs[8]  = '{8'h08, 8'h00, 8'h00, 3, 1, 4'd7,  8'h01};
    vecs[9]  = '{8'h8A, 8'h44, 8'h55, 3, 5, 4'd11, 8'h55};
    vecs[10] = '{8'h0A, 8'h00, 8'h00, 2, 1, 4'd10, 8'h44};
    vecs[11] = '{8'h10, 8'h00, 8'h00, 1, 1, 4'd3,  8'hA5};

    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    bus.ss      = 1'b1;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    rst         = 1'b1;

    // Reset asserted before any clock edge: outputs must settle at once.
    #2 rst = 1'b0;
    #1;
    chk("reset_reg_out", reg_out, 128'h0);
    chk("reset_tx_latch", 128'(bus.tx_latch), 128'(0));
    chk("reset_tx_data", 128'(bus.tx_data), 128'(0));
    @(posedge clk); #3 rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      run_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, vecs[i].hold);
      chk($sformatf("vec%0d_reg%0d", i, vecs[i].idx),
          128'(reg_out[8*vecs[i].idx +: 8]), 128'(vecs[i].val));
      chk($sformatf("vec%0d_all_regs", i), reg_out, model_flat());
    end

    // ss rising together with a byte event in a write frame: byte dropped.
    @(posedge clk); #1 bus.ss = 1'b0;
    repeat (2) @(posedge clk);
    send_byte(8'h85, 1, 1'b0, 8'h00, 1'b0, 4'h0);
    @(posedge clk); #1;
    bus.rx_data = 8'hEE;
    bus.rx_rdy  = 1'b1;
    bus.ss      = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
    // Further byte while deselected is ignored as well.
    @(posedge clk); #1;
    bus.rx_data = 8'hDD;
    bus.rx_rdy  = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ss_wins_reg5", 128'(reg_out[47:40]), 128'(8'h00));
    chk("ss_wins_all_regs", reg_out, model_flat());

    // Reset in the middle of a read frame, asserted and released between edges.
    @(posedge clk); #1 bus.ss = 1'b0;
    repeat (2) @(posedge clk);
    send_byte(8'h07, 1, 1'b1, model[7], 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_tx_data", 128'(bus.tx_data), 128'(model[7]));
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk("midframe_reset_reg_out", reg_out, model_flat());
    chk("midframe_reset_tx_data", 128'(bus.tx_data), 128'(0));
    chk("midframe_reset_tx_latch", 128'(bus.tx_latch), 128'(0));
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("after_release_reg_out", reg_out, 128'h0);
    bus.ss = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(8'h81, 8'h99, 8'h00, 2, 1);
    chk("post_reset_reg1", 128'(reg_out[15:8]), 128'(8'h99));
    chk("post_reset_all_regs", reg_out, model_flat());

`ifdef SPI_CMD_REGFILE_WSTB_EN
    chk("wr_q_drained", 128'(wr_q.size()), 128'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
Byte-level command decoder and register file directly downstream of spi_slave. It consumes received bytes (spi_slave data_out/data_rdy) and returns read data (spi_slave data_in/data_latch). Each ss-low frame is one transaction: a command byte, then burst data bytes with address auto-increment. The flat register outputs drive the rest of the chip's configuration logic.

Parameters:
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W (16 by default)
RESET_VAL, 8'h00, reset value of every register

Ports:
clk  input  1  system clock; same clock as spi_slave
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
ss  input  1  slave select, active-low, synchronous to clk; high = frame idle
rx_data  input  8  received byte (spi_slave data_out)
rx_rdy  input  1  received-byte-valid level (spi_slave data_rdy); a byte is taken on its 0->1 edge
tx_data  output  8  byte to shift out next (to spi_slave data_in)
tx_latch  output  1  one-cycle pulse: spi_slave loads tx_data (to spi_slave data_latch)
reg_out  output  8*NUM_REGS  flat register contents; reg n = reg_out[8n+7:8n]

Behaviour:
- Reset (rst=0, asynchronous): all registers = RESET_VAL; tx_data=8'h00; tx_latch=0; addr=0; state=IDLE; rx_rdy edge detector = 0.
- Byte event: rx_rdy=1 and rx_rdy_q=0 (rx_rdy_q is rx_rdy registered). A level held high produces exactly one event.
- Command byte: bit7 = 1 write, 0 read. bits[6:0] = start address. If bits[6:ADDR_W] != 0, the frame is invalid.
- FSM states:
  - IDLE: ss=0 -> CMD.
  - CMD: byte event -> WRITE (valid write), READ (valid read), or DISCARD (invalid). Load addr = cmd[ADDR_W-1:0].
  - WRITE: each byte event writes rx_data to reg[addr] on that clk edge, then addr = addr+1.
  - READ: on entry cycle, tx_data = reg[addr] and tx_latch = 1 for one cycle. Each later byte event sets addr = addr+1, then the next cycle loads tx_data = reg[new addr] with a one-cycle tx_latch. Received bytes are ignored.
  - DISCARD: byte events ignored, no writes. On entry, tx_data = 8'h00 with a one-cycle tx_latch.
  - Any state: ss=1 sampled -> IDLE next cycle. tx_data holds its last value.
- Read latency: tx_latch asserts 1 clk after the byte event that triggered it.
- Address arithmetic: modulo NUM_REGS. 0xF+1 wraps to 0x0 at default ADDR_W.
- Simultaneous events:
  - ss=1 and a byte event in the same cycle: ss wins, the byte is dropped, no write.
  - A byte event while tx_latch is high is still processed.
- Frame aborted mid-burst: writes already done persist; nothing is partially written (writes are byte-atomic).
- A new frame always starts in CMD. No state carries over between frames except register contents.
- Reset mid-frame: immediate return to the reset values above, regardless of ss.

Optional Feature:
Macro SPI_CMD_REGFILE_WSTB_EN.
- Defined: adds outputs wr_stb (1 bit) and wr_addr (ADDR_W bits). wr_stb pulses for one cycle, in the cycle after each register write, with wr_addr = the address written. Reset values: wr_stb=0, wr_addr=0. Lets consumers react to configuration changes.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset -> every reg_out byte = 8'h00, tx_latch=0, tx_data=8'h00. Assert and release rst asynchronously between clk edges; check the outputs change immediately.
- Frame with bytes 8'h83, 8'hA5, 8'h5A -> reg3=8'hA5, reg4=8'h5A, all other registers unchanged. Raise ss; a further byte event is ignored.
- After the write above, frame with bytes 8'h03, dummy, dummy -> tx_latch pulses 1 clk after each byte event, with tx_data = 8'hA5, then 8'h5A, then reg5 (8'h00).
- Burst wrap: frame 8'h8F, 8'h11, 8'h22 -> reg15=8'h11, reg0=8'h22. Read frame 8'h0F, dummy -> tx_data 8'h11 then 8'h22.
- Invalid address: frame 8'hC0, 8'hFF -> no register changes, one tx_latch with tx_data=8'h00. Then ss=1 in the same cycle as a byte event on a valid write frame -> no write.
- Held rx_rdy: rx_rdy high for 5 clks in a write frame -> exactly one write. With SPI_CMD_REGFILE_WSTB_EN defined, a write to reg 2 -> wr_stb pulses for one cycle with wr_addr=2.
